fetch_prefetch_stage: RTL and testbench

//  Next-generation fetch stage: decoupled prefetcher that keeps up to MAX_OUTST OBI reads in flight
//  and buffers returned instructions in a FIFO_DEPTH-entry queue ahead of decode.

---
 rtl/fetch_prefetch_stage_pkg.sv | 17 +
 rtl/fetch_prefetch_stage_fifo.sv | 55 +++++
 rtl/fetch_prefetch_stage.sv | 140 ++++++++++++++
 tb/tb_fetch_prefetch_stage.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_prefetch_stage_pkg.sv
// Shared types and constants for the prefetching fetch stage.
// Queue entries carry the instruction together with its PC.
package fetch_prefetch_stage_pkg;

  localparam logic [63:0] RESET_ADDR_DEF = 64'h0000_0000_8000_0000;
  localparam logic [3:0]  BE_WORD        = 4'hF;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [63:0] word_align(input logic [63:0] a);
    return a & ~64'h3;
  endfunction

endpackage

// File: rtl/fetch_prefetch_stage_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries ahead of decode.
// Flush empties the queue in a single cycle.
module fetch_prefetch_stage_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  logic [WIDTH-1:0]       i_data,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rptr];
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/fetch_prefetch_stage.sv
// Decoupled prefetcher: reserves queue space per OBI read, drops
// responses that belong to fetch streams abandoned by a redirect.
module fetch_prefetch_stage
  import fetch_prefetch_stage_pkg::*;
#(
  parameter logic [63:0] RESET_ADDR = RESET_ADDR_DEF,
  parameter int          FIFO_DEPTH = 4,
  parameter int          MAX_OUTST  = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [63:0] redirect_addr_i,
  output logic        imem_req_o,
  input  logic        imem_gnt_i,
  output logic [63:0] imem_addr_o,
  output logic        imem_we_o,
  output logic [3:0]  imem_be_o,
  output logic [31:0] imem_wdata_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] instr_o,
  output logic [63:0] pc_o,
  output logic [63:0] next_pc_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] OUTST_C = CW'(MAX_OUTST);

  logic          r_req;
  logic          r_stale;
  logic [63:0]   r_addr;
  logic [63:0]   r_fetch_pc;
  logic [63:0]   r_resp_pc;
  logic [CW-1:0] r_outst;
  logic [CW-1:0] r_discard;

  logic          w_gnt;
  logic          w_rv;
  logic          w_push;
  logic          w_pop;
  logic          w_issue;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_cnt_n;
  logic [CW-1:0] w_outst_n;
  logic [63:0]   w_fpc;
  logic [63:0]   w_target;
  logic [95:0]   w_qdata;
  fetch_entry_t  w_head;

  assign w_target  = word_align(redirect_addr_i);
  assign w_gnt     = r_req & imem_gnt_i;
  assign w_rv      = imem_rvalid_i & (r_outst != '0);
  assign w_push    = w_rv & ~redirect_i & (r_discard == '0);
  assign w_pop     = ~w_empty & ready_i & ~redirect_i;
  assign w_outst_n = r_outst + CW'(w_gnt) - CW'(w_rv);
  assign w_cnt_n   = redirect_i ? '0
                   : w_count + CW'(w_push) - CW'(w_pop);
  assign w_fpc     = redirect_i ? w_target : r_fetch_pc;
  // Every queued or in-flight read keeps one queue slot reserved.
  assign w_issue   = ({1'b0, w_cnt_n} + {1'b0, w_outst_n} < DEPTH_C)
                   && (w_outst_n < OUTST_C);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_req      <= 1'b0;
      r_stale    <= 1'b0;
      r_addr     <= RESET_ADDR;
      r_fetch_pc <= RESET_ADDR;
    end else if (r_req & ~imem_gnt_i) begin
      r_fetch_pc <= w_fpc;
      r_stale    <= r_stale | redirect_i;
    end else begin
      r_req   <= w_issue;
      r_stale <= 1'b0;
      if (w_issue) begin
        r_addr     <= w_fpc;
        r_fetch_pc <= w_fpc + 64'd4;
      end else begin
        r_fetch_pc <= w_fpc;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_outst   <= '0;
      r_discard <= '0;
      r_resp_pc <= RESET_ADDR;
    end else begin
      r_outst <= w_outst_n;
      if (redirect_i) begin
        r_discard <= w_outst_n;
        r_resp_pc <= w_target;
      end else begin
        // A held request granted after a redirect returns stale data.
        r_discard <= r_discard
                   - CW'(w_rv & (r_discard != '0))
                   + CW'(w_gnt & r_stale);
        if (w_push) r_resp_pc <= r_resp_pc + 64'd4;
      end
    end
  end

  fetch_prefetch_stage_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_i),
    .i_data  ({r_resp_pc, imem_rdata_i}),
    .o_data  (w_qdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_head       = w_qdata;
  assign imem_req_o   = r_req;
  assign imem_addr_o  = r_addr;
  assign imem_we_o    = 1'b0;
  assign imem_be_o    = BE_WORD;
  assign imem_wdata_o = 32'h0;
  assign valid_o      = ~w_empty;
  assign instr_o      = valid_o ? w_head.instr : 32'h0;
  assign pc_o         = valid_o ? w_head.pc : 64'h0;
  assign next_pc_o    = pc_o + 64'd4;

  a_no_overflow: assert property (
    @(posedge clk_i) disable iff (rst_i) !(w_push && w_full));

endmodule

// File: tb/tb_fetch_prefetch_stage.sv
// Directed and randomised bench for the prefetching fetch stage.
// Memory returns {addr[15:0], ~addr[15:0]} for every word.
module tb_fetch_prefetch_stage;

  localparam logic [63:0] RST_A = 64'h8000_0000;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [63:0] raddr;
  logic        req;
  logic        gnt;
  logic [63:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        valid;
  logic        ready;
  logic [31:0] instr;
  logic [63:0] pc;
  logic [63:0] npc;

  always #5 clk = ~clk;

  fetch_prefetch_stage dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .redirect_i      (redirect),
    .redirect_addr_i (raddr),
    .imem_req_o      (req),
    .imem_gnt_i      (gnt),
    .imem_addr_o     (addr),
    .imem_we_o       (we),
    .imem_be_o       (be),
    .imem_wdata_o    (wdata),
    .imem_rvalid_i   (rvalid),
    .imem_rdata_i    (rdata),
    .valid_o         (valid),
    .ready_i         (ready),
    .instr_o         (instr),
    .pc_o            (pc),
    .next_pc_o       (npc)
  );

  typedef struct {
    logic [63:0] a;
    int          tag;
    int          due;
  } rsp_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] ins;
  } ent_t;

  rsp_t        rq[$];
  ent_t        expq[$];
  logic [63:0] mpc;
  logic [63:0] p_addr;
  logic [63:0] hold_a;
  int          epoch;
  int          cyc;
  int          last_due;
  int          grants;
  int          g0;
  bit          stale_pend;
  bit          p_hold;
  bit          stray;
  logic        s_req;
  logic        s_valid;
  logic [63:0] s_addr;
  logic [63:0] s_pc;
  logic [31:0] s_instr;
  int          checks   = 0;
  int          failures = 0;

  function automatic logic [31:0] mem(input logic [63:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock cycle: compare, drive inputs, advance the model.
  task automatic step(input bit g, input bit rdy, input bit rd,
                      input logic [63:0] tgt, input int dly);
    rsp_t r;
    bit   dlv;
    int   d;
    @(negedge clk);
    cyc++;
    s_req   = req;
    s_addr  = addr;
    s_valid = valid;
    s_pc    = pc;
    s_instr = instr;
    chk("valid_o", 64'(valid), 64'(expq.size() != 0));
    if (valid && expq.size() != 0) begin
      chk("pc_o", pc, expq[0].pc);
      chk("instr_o", 64'(instr), 64'(expq[0].ins));
      chk("next_pc_o", npc, expq[0].pc + 64'd4);
    end
    if (p_hold) begin
      chk("req_held", 64'(req), 64'd1);
      chk("addr_held", addr, p_addr);
    end
    dlv      = (rq.size() != 0) && (rq[0].due <= cyc);
    gnt      = g;
    ready    = rdy;
    redirect = rd;
    raddr    = tgt;
    rvalid   = dlv | stray;
    rdata    = dlv ? mem(rq[0].a) : 32'hDEAD_BEEF;
    stray    = 1'b0;
    if (valid && rdy && !rd && expq.size() != 0) void'(expq.pop_front());
    if (dlv) begin
      r = rq.pop_front();
      if (r.tag == epoch && !rd) expq.push_back('{pc: r.a, ins: mem(r.a)});
    end
    if (req && g) begin
      grants++;
      if (stale_pend) begin
        stale_pend = 1'b0;
        r.tag = -1;
      end else begin
        chk("fetch_addr", addr, mpc);
        mpc   = mpc + 64'd4;
        r.tag = epoch;
      end
      r.a = addr;
      d = cyc + dly;
      if (d <= last_due) d = last_due + 1;
      r.due = d;
      last_due = d;
      rq.push_back(r);
      chk("max_outst", 64'(rq.size() <= MAXO), 64'd1);
    end
    chk("queue_bound", 64'(expq.size() <= DEPTH), 64'd1);
    if (rd) begin
      expq.delete();
      epoch++;
      mpc = tgt & ~64'h3;
      if (req && !g) stale_pend = 1'b1;
    end
    p_hold = req && !g;
    p_addr = addr;
  endtask

  task automatic wait_valid(input string nm, input logic [63:0] epc,
                            input logic [31:0] eins);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      step(1'b1, 1'b1, 1'b0, 64'h0, 1);
      got = s_valid;
    end
    chk({nm, "_seen"}, 64'(got), 64'd1);
    if (got) begin
      chk({nm, "_pc"}, s_pc, epc);
      chk({nm, "_instr"}, 64'(s_instr), 64'(eins));
    end
  endtask

  task automatic rst_pulse();
    #2 rst = 1'b1;
    #1;
    chk("arst_req", 64'(req), 64'd0);
    chk("arst_valid", 64'(valid), 64'd0);
    chk("arst_pc", pc, 64'd0);
    chk("arst_instr", 64'(instr), 64'd0);
    chk("arst_npc", npc, 64'd4);
    rq.delete();
    expq.delete();
    epoch++;
    mpc        = RST_A;
    stale_pend = 1'b0;
    p_hold     = 1'b0;
    gnt        = 1'b0;
    rvalid     = 1'b0;
    redirect   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    ready = 1'b0; redirect = 1'b0; raddr = '0;
    mpc = RST_A; epoch = 0; cyc = 0; last_due = 0; grants = 0;
    stale_pend = 1'b0; p_hold = 1'b0; stray = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req", 64'(req), 64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_pc", pc, 64'd0);
    chk("rst_npc", npc, 64'd4);
    chk("tie_we", 64'(we), 64'd0);
    chk("tie_be", 64'(be), 64'hF);
    chk("tie_wdata", 64'(wdata), 64'd0);
    rst = 1'b0;

    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 1'b1, 1'b0, 64'h0, 1);
      if (i == 1) chk("t1_req", 64'(s_req), 64'd1);
      if (i <= 3) chk("t1_addr", s_addr, RST_A + 64'(4 * (i - 1)));
      if (i >= 3) begin
        chk("t1_valid", 64'(s_valid), 64'd1);
        chk("t1_pc", s_pc, RST_A + 64'(4 * (i - 3)));
      end
      if (i == 3) chk("t1_instr0", 64'(s_instr), 64'h0000_FFFF);
      if (i == 4) chk("t1_instr1", 64'(s_instr), 64'h0004_FFFB);
    end

    repeat (4) step(1'b0, 1'b1, 1'b0, 64'h0, 1);
    g0 = grants;
    repeat (10) step(1'b1, 1'b0, 1'b0, 64'h0, 1);
    chk("t2_grants", 64'(grants - g0), 64'd4);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 64'h0, 1);
      chk("t2_valid", 64'(s_valid), 64'd1);
      chk("t2_pc", s_pc, 64'h8000_0030 + 64'(4 * i));
    end

    step(1'b1, 1'b1, 1'b0, 64'h0, 3);
    step(1'b1, 1'b1, 1'b0, 64'h0, 3);
    chk("t3_outst", 64'(rq.size()), 64'd2);
    step(1'b1, 1'b1, 1'b1, 64'h1000, 1);
    wait_valid("t3", 64'h1000, 32'h1000_EFFF);

    step(1'b0, 1'b1, 1'b0, 64'h0, 1);
    step(1'b0, 1'b1, 1'b0, 64'h0, 1);
    chk("t4_req", 64'(s_req), 64'd1);
    hold_a = s_addr;
    step(1'b0, 1'b1, 1'b1, 64'h1003, 1);
    repeat (3) begin
      step(1'b0, 1'b1, 1'b0, 64'h0, 1);
      chk("t4_hold_addr", s_addr, hold_a);
    end
    step(1'b1, 1'b1, 1'b0, 64'h0, 1);
    step(1'b1, 1'b1, 1'b0, 64'h0, 1);
    chk("t4_new_req", 64'(s_req), 64'd1);
    chk("t4_new_addr", s_addr, 64'h1000);
    wait_valid("t4", 64'h1000, 32'h1000_EFFF);

    step(1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1);
    wait_valid("wrap", 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFC_0003);
    step(1'b1, 1'b1, 1'b0, 64'h0, 1);
    chk("wrap_valid", 64'(s_valid), 64'd1);
    chk("wrap_pc", s_pc, 64'h0);

    repeat (3) step(1'b1, 1'b1, 1'b0, 64'h0, 1);
    rst_pulse();
    stray = 1'b1;
    step(1'b0, 1'b1, 1'b0, 64'h0, 1);
    chk("rr_req", 64'(s_req), 64'd1);
    chk("rr_addr", s_addr, RST_A);
    wait_valid("rr", RST_A, 32'h0000_FFFF);

    for (int i = 0; i < 400; i++) begin
      logic [63:0] t;
      t = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) t = 64'hFFFF_FFFF_FFFF_FFF0 | {60'h0, t[3:0]};
      step($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0, t, int'($urandom_range(1, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
